// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg
// Shared definitions for the PLL lock supervisor:
//   - sup_state_e : supervisor FSM states
//   - cnt_width() : width of the shared phase counter, sized so it can hold
//                   (largest phase length - 1)
package pll_sup_pkg;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } sup_state_e;

    // Bits needed to count 0 .. max(a, b, c) - 1, never less than one bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        m = (b > m) ? b : m;
        m = (c > m) ? c : m;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// bit_sync
// N-flop single-bit synchroniser for a level that is asynchronous to clk.
// Ports:
//   clk  in   destination clock
//   rst  in   synchronous active-high reset, clears every stage to 0
//   d    in   asynchronous input level
//   q    out  synchronised level, N cycles behind d
module bit_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] sync_r;

    // Shift the asynchronous level through the synchroniser chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[N-2:0], d};
        end
    end

    assign q = sync_r[N-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
// Drives the memory-clock PLL reset, qualifies its lock as stable before
// releasing the memory-domain reset, and re-initialises the PLL on lock loss,
// lock timeout or a software request. Runs entirely in the reference domain.
// Ports:
//   clk          in   reference clock (only clock)
//   rst          in   synchronous active-high reset
//   pll_lock     in   raw PLL lock, asynchronous to clk
//   force_relock in   single-cycle request to re-initialise the PLL
//   pll_reset    out  PLL reset, active-high
//   mem_rst      out  memory-domain reset, active-high
//   locked       out  high only while running on a qualified lock
//   lock_lost    out  one-cycle pulse when lock drops while running
//   relock_cnt   out  saturating count of lock losses plus lock timeouts
module pll_lock_supervisor #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_lock,
    input  logic             force_relock,
    output logic             pll_reset,
    output logic             mem_rst,
    output logic             locked,
    output logic             lock_lost,
    output logic [CNT_W-1:0] relock_cnt
);

    import pll_sup_pkg::*;

    localparam int CW = cnt_width(PLL_RST_CYCLES, STABLE_CYCLES, LOCK_TIMEOUT);

    // Terminal counts: a phase of length L ends when cnt_r holds L-1.
    localparam logic [CW-1:0]    RST_LAST     = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0]    STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0]    TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RELOCK_MAX   = {CNT_W{1'b1}};

    sup_state_e       state_r;
    logic [CW-1:0]    cnt_r;
    logic             lock_s;
    logic [CNT_W-1:0] relock_inc_s;

    bit_sync #(
        .N (SYNC_STAGES)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock_s)
    );

    // Saturating next value for the relock counter.
    assign relock_inc_s = (relock_cnt == RELOCK_MAX) ? relock_cnt
                                                     : relock_cnt + CNT_W'(1);

    // Supervisor FSM; outputs are registered alongside the state so they
    // always reflect the state being entered on this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= PLL_RST;
            cnt_r      <= '0;
            pll_reset  <= 1'b1;
            mem_rst    <= 1'b1;
            locked     <= 1'b0;
            lock_lost  <= 1'b0;
            relock_cnt <= '0;
        end else begin
            lock_lost <= 1'b0;
            case (state_r)
                // Hold the PLL in reset for a fixed time; requests are ignored
                // so the hold can never be stretched.
                PLL_RST: begin
                    if (cnt_r == RST_LAST) begin
                        state_r   <= WAIT_LOCK;
                        cnt_r     <= '0;
                        pll_reset <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                // A timeout is a counted failure even if a request coincides.
                WAIT_LOCK: begin
                    if (!lock_s && (cnt_r == TIMEOUT_LAST)) begin
                        state_r    <= PLL_RST;
                        cnt_r      <= '0;
                        pll_reset  <= 1'b1;
                        mem_rst    <= 1'b1;
                        locked     <= 1'b0;
                        relock_cnt <= relock_inc_s;
                    end else if (force_relock) begin
                        state_r   <= PLL_RST;
                        cnt_r     <= '0;
                        pll_reset <= 1'b1;
                        mem_rst   <= 1'b1;
                        locked    <= 1'b0;
                    end else if (lock_s) begin
                        state_r <= STABLE;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                // Any dropout restarts qualification without counting.
                STABLE: begin
                    if (force_relock) begin
                        state_r   <= PLL_RST;
                        cnt_r     <= '0;
                        pll_reset <= 1'b1;
                        mem_rst   <= 1'b1;
                        locked    <= 1'b0;
                    end else if (!lock_s) begin
                        state_r <= WAIT_LOCK;
                        cnt_r   <= '0;
                    end else if (cnt_r == STABLE_LAST) begin
                        state_r <= RUN;
                        cnt_r   <= '0;
                        mem_rst <= 1'b0;
                        locked  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                // Lock loss wins over a coincident request so it is still
                // reported and counted exactly once.
                RUN: begin
                    if (!lock_s) begin
                        state_r    <= PLL_RST;
                        cnt_r      <= '0;
                        pll_reset  <= 1'b1;
                        mem_rst    <= 1'b1;
                        locked     <= 1'b0;
                        lock_lost  <= 1'b1;
                        relock_cnt <= relock_inc_s;
                    end else if (force_relock) begin
                        state_r   <= PLL_RST;
                        cnt_r     <= '0;
                        pll_reset <= 1'b1;
                        mem_rst   <= 1'b1;
                        locked    <= 1'b0;
                    end else begin
                        cnt_r <= '0;
                    end
                end
                default: begin
                    state_r   <= PLL_RST;
                    cnt_r     <= '0;
                    pll_reset <= 1'b1;
                    mem_rst   <= 1'b1;
                    locked    <= 1'b0;
                end
            endcase
        end
    end

endmodule
